// File: rtl/imem_serial_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_serial_loader_if
// Description : Byte-stream handshake and instruction-memory write bus
//               shared between the program loader and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_serial_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_written;

    // Environment side: sources the stream, observes the memory writes/status
    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_hold, load_done, load_error, words_written
    );

    // Loader side
    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output cpu_hold, load_done, load_error, words_written
    );
endinterface
`default_nettype wire

// File: rtl/imem_serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_serial_loader
// Description : Receives a framed byte stream (16-bit word count, big-endian
//               words, XOR checksum), writes each word to instruction memory
//               and holds the CPU while loading or after a bad frame.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_serial_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  wire                    clk,
    input  wire                    reset,
    imem_serial_loader_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] C_MAX_WORDS = 17'(MAX_WORDS);

    state_t      state_q,   state_d;
    logic [15:0] len_q,     len_d;
    logic [1:0]  bcnt_q,    bcnt_d;
    logic [23:0] asm_q,     asm_d;
    logic [7:0]  csum_q,    csum_d;
    logic [15:0] wcnt_q,    wcnt_d;
    logic        we_q,      we_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        hold_q,    hold_d;
    logic        done_q,    done_d;
    logic        err_q,     err_d;

    logic        ready;
    logic        accept;
    logic [15:0] len_new;

    assign ready   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                     (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign accept  = bus.byte_valid && ready;
    assign len_new = {len_q[15:8], bus.byte_data};

    // Next-state and datapath: frame parsing, word assembly, write strobe
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        wcnt_d  = wcnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.start) begin
                    state_d = ST_LEN_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    wcnt_d  = 16'd0;
                    csum_d  = 8'd0;
                    bcnt_d  = 2'd0;
                    hold_d  = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = bus.byte_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = len_new;
                    if ({1'b0, len_new} > C_MAX_WORDS) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else if (len_new == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                        bcnt_d  = 2'd0;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ bus.byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Word complete: strobe is registered, address uses the
                        // pre-increment count, count advances with the strobe.
                        we_d    = 1'b1;
                        wdata_d = {asm_q, bus.byte_data};
                        addr_d  = ADDR_BASE + {14'd0, wcnt_q, 2'b00};
                        wcnt_d  = wcnt_q + 16'd1;
                        if ((wcnt_q + 16'd1) == len_q) begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        asm_d = {asm_q[15:0], bus.byte_data};
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (bus.byte_data == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; async active-low reset abandons any frame in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            len_q   <= 16'd0;
            bcnt_q  <= 2'd0;
            asm_q   <= 24'd0;
            csum_q  <= 8'd0;
            wcnt_q  <= 16'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.byte_ready    = ready;
    assign bus.imem_we       = we_q;
    assign bus.imem_addr     = addr_q;
    assign bus.imem_wdata    = wdata_q;
    assign bus.cpu_hold      = hold_q;
    assign bus.load_done     = done_q;
    assign bus.load_error    = err_q;
    assign bus.words_written = wcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_serial_loader
// Description : Directed self-checking bench; two loaders (base 0x0 and
//               0x100) receive the identical byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_serial_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;

    int n_cmp;
    int n_bad;

    logic [31:0] qa_addr[$];
    logic [31:0] qa_data[$];
    logic [31:0] qb_addr[$];
    logic [31:0] qb_data[$];

    imem_serial_loader_if ifa ();
    imem_serial_loader_if ifb ();

    assign ifa.start      = start;
    assign ifa.byte_valid = byte_valid;
    assign ifa.byte_data  = byte_data;
    assign ifb.start      = start;
    assign ifb.byte_valid = byte_valid;
    assign ifb.byte_data  = byte_data;

    imem_serial_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(64)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    imem_serial_loader #(.ADDR_BASE(32'h0000_0100), .MAX_WORDS(64)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe cycle of both loaders
    always @(negedge clk) begin
        if (ifa.imem_we === 1'b1) begin
            qa_addr.push_back(ifa.imem_addr);
            qa_data.push_back(ifa.imem_wdata);
        end
        if (ifb.imem_we === 1'b1) begin
            qb_addr.push_back(ifb.imem_addr);
            qb_data.push_back(ifb.imem_wdata);
        end
    end

    task automatic clear_queues();
        qa_addr.delete(); qa_data.delete();
        qb_addr.delete(); qb_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (ifa.byte_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: byte_ready=%b required 1", ifa.byte_ready);
        end else begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ifa.byte_ready, ifa.imem_we, ifa.cpu_hold, ifa.load_done, ifa.load_error} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 00000",
                     {ifa.byte_ready, ifa.imem_we, ifa.cpu_hold, ifa.load_done, ifa.load_error});
        end
        n_cmp++;
        if ({ifa.imem_addr, ifa.imem_wdata, ifa.words_written} !== 80'd0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h/%h/%h required 0",
                     ifa.imem_addr, ifa.imem_wdata, ifa.words_written);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        clear_queues();
        pulse_start();
        n_cmp++;
        if ({ifa.cpu_hold, ifa.byte_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL single_start: hold,ready=%b required 11", {ifa.cpu_hold, ifa.byte_ready});
        end
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        n_cmp++;
        if ({ifa.imem_we, ifa.imem_addr, ifa.imem_wdata, ifa.words_written} !==
            {1'b1, 32'h0000_0000, 32'h2008_0005, 16'd1}) begin
            n_bad++;
            $display("FAIL single_strobe: we=%b addr=%h data=%h ww=%0d required 1/00000000/20080005/1",
                     ifa.imem_we, ifa.imem_addr, ifa.imem_wdata, ifa.words_written);
        end
        n_cmp++;
        if (ifa.cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL single_hold_before_csum: got %b required 1", ifa.cpu_hold);
        end
        send_byte(8'h2D);
        n_cmp++;
        if ({ifa.load_done, ifa.load_error, ifa.cpu_hold, ifa.byte_ready} !== 4'b1000) begin
            n_bad++;
            $display("FAIL single_status: done,err,hold,ready=%b required 1000",
                     {ifa.load_done, ifa.load_error, ifa.cpu_hold, ifa.byte_ready});
        end
        n_cmp++;
        if (qa_addr.size() != 1 || qb_addr.size() != 1) begin
            n_bad++;
            $display("FAIL single_count: writes a=%0d b=%0d required 1/1", qa_addr.size(), qb_addr.size());
        end else begin
            n_cmp++;
            if (qb_addr[0] !== 32'h0000_0100 || qb_data[0] !== 32'h2008_0005) begin
                n_bad++;
                $display("FAIL single_base: addr=%h data=%h required 00000100/20080005", qb_addr[0], qb_data[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  frame [0:15];
        logic [31:0] exp_d [0:2];
        int stalls;
        frame = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                  8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCC, 8'h00};
        exp_d = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
        stalls = 0;
        clear_queues();
        pulse_start();
        byte_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            byte_data = frame[i];
            if (ifa.byte_ready !== 1'b1 || ifb.byte_ready !== 1'b1) stalls++;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        n_cmp++;
        if (stalls != 0) begin
            n_bad++;
            $display("FAIL b2b_ready: stall cycles=%0d required 0", stalls);
        end
        n_cmp++;
        if ({ifa.load_done, ifa.load_error, ifa.words_written} !== {1'b1, 1'b0, 16'd3}) begin
            n_bad++;
            $display("FAIL b2b_status: done=%b err=%b ww=%0d required 1/0/3",
                     ifa.load_done, ifa.load_error, ifa.words_written);
        end
        n_cmp++;
        if (qa_addr.size() != 3 || qb_addr.size() != 3) begin
            n_bad++;
            $display("FAIL b2b_count: writes a=%0d b=%0d required 3/3", qa_addr.size(), qb_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (qb_addr[i] !== 32'h100 + 32'(4 * i) || qb_data[i] !== exp_d[i] ||
                    qa_addr[i] !== 32'(4 * i)) begin
                    n_bad++;
                    $display("FAIL b2b_word%0d: b addr=%h data=%h a addr=%h required %h/%h/%h",
                             i, qb_addr[i], qb_data[i], qa_addr[i],
                             32'h100 + 32'(4 * i), exp_d[i], 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_bad_checksum();
        clear_queues();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h2C);
        n_cmp++;
        if ({ifa.load_error, ifa.load_done, ifa.cpu_hold, ifa.words_written} !== {3'b101, 16'd1}) begin
            n_bad++;
            $display("FAIL badcs_status: err=%b done=%b hold=%b ww=%0d required 1/0/1/1",
                     ifa.load_error, ifa.load_done, ifa.cpu_hold, ifa.words_written);
        end
        n_cmp++;
        if (qa_addr.size() != 1) begin
            n_bad++;
            $display("FAIL badcs_writes: got %0d required 1", qa_addr.size());
        end
    endtask

    task automatic test_oversize();
        clear_queues();
        pulse_start();
        send_byte(8'h00); send_byte(8'h41);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ifa.load_error, ifa.load_done, ifa.cpu_hold, ifa.byte_ready} !== 4'b1010) begin
            n_bad++;
            $display("FAIL oversize_status: err,done,hold,ready=%b required 1010",
                     {ifa.load_error, ifa.load_done, ifa.cpu_hold, ifa.byte_ready});
        end
        n_cmp++;
        if (qa_addr.size() != 0 || ifa.words_written !== 16'd0) begin
            n_bad++;
            $display("FAIL oversize_writes: got %0d ww=%0d required 0/0", qa_addr.size(), ifa.words_written);
        end
    endtask

    task automatic test_zero_len_reload();
        clear_queues();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        n_cmp++;
        if ({ifa.load_done, ifa.load_error, ifa.cpu_hold} !== 3'b100 || qa_addr.size() != 0) begin
            n_bad++;
            $display("FAIL zero_len: done,err,hold=%b writes=%0d required 100/0",
                     {ifa.load_done, ifa.load_error, ifa.cpu_hold}, qa_addr.size());
        end
        pulse_start();
        n_cmp++;
        if ({ifa.cpu_hold, ifa.load_done, ifa.words_written} !== {2'b10, 16'd0}) begin
            n_bad++;
            $display("FAIL reload_start: hold=%b done=%b ww=%0d required 1/0/0",
                     ifa.cpu_hold, ifa.load_done, ifa.words_written);
        end
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h22);
        n_cmp++;
        if (ifa.load_done !== 1'b1 || qa_addr.size() != 1) begin
            n_bad++;
            $display("FAIL reload_status: done=%b writes=%0d required 1/1", ifa.load_done, qa_addr.size());
        end else begin
            n_cmp++;
            if (qa_addr[0] !== 32'h0 || qa_data[0] !== 32'hDEAD_BEEF) begin
                n_bad++;
                $display("FAIL reload_word: addr=%h data=%h required 00000000/deadbeef", qa_addr[0], qa_data[0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] frame [0:10];
        frame = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        clear_queues();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(frame[i]);
        n_cmp++;
        if (qa_addr.size() != 1 || qa_data[0] !== 32'h0102_0304) begin
            n_bad++;
            $display("FAIL midrst_pre: writes=%0d required 1 with 01020304", qa_addr.size());
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.byte_ready, ifa.imem_we, ifa.cpu_hold, ifa.load_done, ifa.load_error,
             ifa.imem_addr, ifa.imem_wdata, ifa.words_written} !== 85'd0) begin
            n_bad++;
            $display("FAIL midrst_async: ready=%b we=%b hold=%b ww=%0d wdata=%h required all 0",
                     ifa.byte_ready, ifa.imem_we, ifa.cpu_hold, ifa.words_written, ifa.imem_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        // start together with a valid byte: the byte must not be taken in IDLE
        start = 1'b1; byte_valid = 1'b1; byte_data = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0; byte_valid = 1'b0;
        for (int i = 0; i < 11; i++) send_byte(frame[i]);
        n_cmp++;
        if ({ifa.load_done, ifa.load_error, ifa.cpu_hold, ifa.words_written} !== {3'b100, 16'd2}) begin
            n_bad++;
            $display("FAIL midrst_reload: done=%b err=%b hold=%b ww=%0d required 1/0/0/2",
                     ifa.load_done, ifa.load_error, ifa.cpu_hold, ifa.words_written);
        end
        n_cmp++;
        if (qa_addr.size() != 3) begin
            n_bad++;
            $display("FAIL midrst_writes: got %0d required 3", qa_addr.size());
        end else begin
            n_cmp++;
            if (qa_addr[2] !== 32'h4 || qa_data[2] !== 32'h0506_0708) begin
                n_bad++;
                $display("FAIL midrst_word1: addr=%h data=%h required 00000004/05060708",
                         qa_addr[2], qa_data[2]);
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bad_checksum();
        test_oversize();
        test_zero_len_reload();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
